mul_s8s8_lo8_share: RTL and testbench
=====================================

// Module: mul_s8s8_lo8_share
// PURPOSE
//  Shares one 3-stage signed 8x8 multiplier (low 8 bits of product, mul_s8s8_lo8_p3) between N_REQ requesters.
//  Round-robin arbitration on the request side; each request's requester ID rides alongside the pipeline as a tag.
//  Results leave on a single tagged valid/ready output port.
//  Sits between SPU lanes and the shared DSP multiplier in the eval_spu64 datapath.
// PARAMETERS
//  N_REQ     4   number of requesters; legal range 2..16
//  ID_BITS   2   width of the requester tag; must be >= clog2(N_REQ)
// PORTS
//  CLK       in   1            clock; all logic is on the rising edge
//  RESET     in   1            synchronous reset, active-high
//  S_VALID   in   N_REQ        request valid, one bit per requester
//  S_A       in   N_REQ*8      signed operand A; requester i uses bits [8i+7:8i]
//  S_B       in   N_REQ*8      signed operand B; requester i uses bits [8i+7:8i]
//  S_READY   out  N_REQ        one-hot (or zero) acceptance; the request is taken when S_VALID[i] & S_READY[i]
//  M_VALID   out  1            result valid
//  M_ID      out  ID_BITS      requester index that owns M_P
//  M_P       out  8            signed result: low 8 bits of A*B (two's-complement wrap)
//  M_READY   in   1            downstream accepts the result
//  BUSY      out  1            at least one pipeline stage holds a valid entry
// BEHAVIOUR
//  Reset
//   - Synchronous. Clears stage valids v0..v2 and sets the RR pointer to 0.
//   - After reset: M_VALID=0, BUSY=0, S_READY=0 (until some S_VALID is asserted), M_ID=0.
//   - M_P is undefined while M_VALID=0, because the multiplier has no reset.
//   - RESET asserted mid-operation discards all in-flight entries. No result is emitted for them.
//  Stall
//   - stall = v2 & ~M_READY. The multiplier CE and the tag/valid pipeline both use ce = ~stall.
//   - There is no bubble collapse: the whole pipeline freezes on a stall.
//  Arbitration
//   - When ce=1, grant the first i with S_VALID[i]=1, searching from ptr, ptr+1, ... mod N_REQ.
//   - S_READY = grant & {N_REQ{ce}}. At most one bit is set. S_READY depends combinationally on S_VALID.
//   - On an accepted request from requester g, ptr <= (g+1) mod N_REQ. Otherwise ptr holds.
//   - A requester may hold S_VALID; its operands must stay stable until accepted.
//  Pipeline
//   - When ce=1: v0 <= |(S_VALID & S_READY), id0 <= g; stage k+1 <= stage k.
//   - A, B driven into the multiplier are the granted requester's operands. Don't-care when there is no grant.
//   - M_VALID = v2, M_ID = id2, M_P = multiplier P.
//   - Latency: a request accepted in cycle t produces M_VALID in cycle t+3 when there are no stalls.
//     Each stall cycle adds exactly 1.
//   - Throughput: 1 result per cycle when M_READY=1 continuously.
//  Simultaneous events
//   - M_READY=1 with v2=1 and a new grant in the same cycle: all three happen; the pipeline advances.
//   - If all S_VALID deassert, bubbles enter the pipeline. Pending results still drain.
//  BUSY = v0|v1|v2.
// STRUCTURE
//  Package spu_mul_pkg:
//   - localparam MUL_LATENCY = 3
//   - localparam MUL_W = 8
//   - function rr_pick(req, ptr) returning the granted index
//  Sub-module rr_arbiter_n: request vector, ptr and enable in; one-hot grant and index out.
//  Pointer register, 3-deep valid/ID shift register and the operand mux live in the top level.
//  The mul_s8s8_lo8_p3 instance is driven with CE=ce.
// TESTING
//  1 Reset, then req0 only with A=7, B=-3, M_READY=1:
//    S_READY[0]=1 in the same cycle; 3 cycles later M_VALID=1, M_ID=0, M_P=8'hEB (-21).
//  2 All 4 requesters valid every cycle, M_READY=1:
//    grants rotate 0,1,2,3,0...; M_ID follows the same order at one result per cycle.
//  3 Overflow wrap: A=-128, B=-128 -> M_P=8'h00; A=127, B=2 -> M_P=8'hFE.
//  4 M_READY=0 for 5 cycles while 3 entries are in flight:
//    S_READY=0, M_VALID and M_P hold stable, no loss or duplication.
//    After release, the results drain in order.
//  5 Assert RESET with 2 entries in flight:
//    the next cycle M_VALID=0 and BUSY=0, no stale result ever appears, and ptr restarts at 0.
//  6 Random valid/ready traffic against a scoreboard:
//    every accepted request is matched by exactly one result with the correct ID and A*B[7:0].

Source files
------------

// File: rtl/spu_mul_pkg.sv
// Shared definitions for the SPU multiplier-sharing block.
//   MUL_LATENCY : pipeline depth of the shared multiplier
//   MUL_W       : operand / result width
//   rr_pick     : round-robin pick over up to 16 requesters
package spu_mul_pkg;

    localparam int MUL_LATENCY = 3;
    localparam int MUL_W       = 8;

    // First set bit of req[n-1:0], searching ptr, ptr+1, ... wrapping at n.
    // Returns 0 when req is empty; callers qualify the result with |req.
    function automatic logic [3:0] rr_pick(input logic [15:0] req,
                                           input logic [3:0]  ptr,
                                           input int          n);
        logic [3:0] pick;
        logic       found;
        int         j;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < 16; k++) begin
            j = int'(ptr) + k;
            if (j >= n) j = j - n;
            if (k < n && !found && req[j[3:0]]) begin
                pick  = j[3:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mul_s8s8_lo8_p3.sv
// Three-stage 8x8 multiplier returning the low 8 bits of the product.
// No reset on the datapath; everything advances only when CE=1.
//   CLK : clock
//   CE  : clock enable for all stages
//   A,B : signed operands
//   P   : low 8 bits of A*B, three enabled cycles after A,B are sampled
module mul_s8s8_lo8_p3
    import spu_mul_pkg::*;
(
    input  logic             CLK,
    input  logic             CE,
    input  logic [MUL_W-1:0] A,
    input  logic [MUL_W-1:0] B,
    output logic [MUL_W-1:0] P
);

    logic [MUL_W-1:0] a_r, b_r, m_r, p_r;

    // The low MUL_W bits of a two's-complement product do not depend on
    // operand signedness, so an MUL_W-wide unsigned multiply is exact here.
    always_ff @(posedge CLK) begin
        if (CE) begin
            a_r <= A;
            b_r <= B;
            m_r <= a_r * b_r;
            p_r <= m_r;
        end
    end

    assign P = p_r;

endmodule

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter, combinational.
//   req   : request vector, one bit per requester
//   ptr   : index with highest priority this cycle
//   en    : grant enable; no grant is issued when low
//   grant : one-hot (or zero) grant
//   idx   : index of the winning requester (valid when any=1)
//   any   : a grant is being issued
module rr_arbiter_n
    import spu_mul_pkg::*;
#(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [IDW-1:0] ptr,
    input  logic           en,
    output logic [N-1:0]   grant,
    output logic [IDW-1:0] idx,
    output logic           any
);

    assign idx   = IDW'(rr_pick(16'(req), 4'(ptr), N));
    assign any   = en & (|req);
    assign grant = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/mul_s8s8_lo8_share.sv
// Shares one 3-stage signed 8x8 (low-8) multiplier among N_REQ requesters.
// Round-robin arbitration; the requester index travels with each entry as a
// tag and comes out on M_ID alongside the product.
//   CLK, RESET      : clock, synchronous active-high reset
//   S_VALID/S_READY : per-requester request handshake (S_READY one-hot)
//   S_A, S_B        : packed per-requester signed operands
//   M_VALID/M_READY : result handshake
//   M_ID, M_P       : owner tag and low 8 bits of A*B
//   BUSY            : any pipeline stage holds a valid entry
module mul_s8s8_lo8_share
    import spu_mul_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int ID_BITS = 2
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_REQ-1:0]       S_VALID,
    input  logic [N_REQ*MUL_W-1:0] S_A,
    input  logic [N_REQ*MUL_W-1:0] S_B,
    output logic [N_REQ-1:0]       S_READY,
    output logic                   M_VALID,
    output logic [ID_BITS-1:0]     M_ID,
    output logic [MUL_W-1:0]       M_P,
    input  logic                   M_READY,
    output logic                   BUSY
);

    logic                                  ce;
    logic [MUL_LATENCY-1:0]                vld_pipe;
    logic [MUL_LATENCY-1:0][ID_BITS-1:0]   id_pipe;
    logic [ID_BITS-1:0]                    ptr, gnt_idx;
    logic [N_REQ-1:0]                      gnt;
    logic                                  gnt_any;
    logic [MUL_W-1:0]                      a, b;

    // Whole pipeline freezes while the head result waits; no bubble collapse.
    assign ce = ~(vld_pipe[MUL_LATENCY-1] & ~M_READY);

    rr_arbiter_n #(.N(N_REQ), .IDW(ID_BITS)) u_arb (
        .req   (S_VALID),
        .ptr   (ptr),
        .en    (ce),
        .grant (gnt),
        .idx   (gnt_idx),
        .any   (gnt_any)
    );

    assign S_READY = gnt;

    always_comb begin
        a = '0;
        b = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (gnt[i]) begin
                a = S_A[i*MUL_W +: MUL_W];
                b = S_B[i*MUL_W +: MUL_W];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            vld_pipe <= '0;
            id_pipe  <= '0;
            ptr      <= '0;
        end else if (ce) begin
            vld_pipe <= {vld_pipe[MUL_LATENCY-2:0], gnt_any};
            id_pipe  <= {id_pipe[MUL_LATENCY-2:0], gnt_idx};
            if (gnt_any)
                ptr <= (gnt_idx == ID_BITS'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end
    end

    mul_s8s8_lo8_p3 u_mul (
        .CLK (CLK),
        .CE  (ce),
        .A   (a),
        .B   (b),
        .P   (M_P)
    );

    assign M_VALID = vld_pipe[MUL_LATENCY-1];
    assign M_ID    = id_pipe[MUL_LATENCY-1];
    assign BUSY    = |vld_pipe;

endmodule

// File: tb/tb_mul_s8s8_lo8_share.sv
module tb_mul_s8s8_lo8_share;

    localparam int N   = 4;
    localparam int IDB = 2;

    logic           CLK = 1'b0;
    logic           RESET;
    logic [N-1:0]   S_VALID;
    logic [N*8-1:0] S_A, S_B;
    logic [N-1:0]   S_READY;
    logic           M_VALID;
    logic [IDB-1:0] M_ID;
    logic [7:0]     M_P;
    logic           M_READY;
    logic           BUSY;

    always #5 CLK = ~CLK;

    mul_s8s8_lo8_share #(.N_REQ(N), .ID_BITS(IDB)) dut (
        .CLK(CLK), .RESET(RESET), .S_VALID(S_VALID), .S_A(S_A), .S_B(S_B),
        .S_READY(S_READY), .M_VALID(M_VALID), .M_ID(M_ID), .M_P(M_P),
        .M_READY(M_READY), .BUSY(BUSY)
    );

    typedef struct packed {
        logic [IDB-1:0] id;
        logic [7:0]     p;
    } exp_t;

    typedef struct {
        int         id;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
    } vec_t;

    exp_t       sb[$];
    int         nchk = 0;
    int         nfail = 0;
    logic [N-1:0] acc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nchk++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] mul8(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] t;
        t = $signed(a) * $signed(b);
        return t[7:0];
    endfunction

    // Sample at the falling edge (scoreboard push/pop), then advance one cycle.
    task automatic tick();
        @(negedge CLK);
        acc = '0;
        if (RESET) begin
            sb.delete();
        end else begin
            if (M_VALID && M_READY) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 32'(M_VALID), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("m_id", 32'(M_ID), 32'(e.id));
                    chk("m_p", 32'(M_P), 32'(e.p));
                end
            end
            chk("s_ready_onehot0", 32'($onehot0(S_READY)), 32'd1);
            for (int i = 0; i < N; i++) begin
                if (S_VALID[i] && S_READY[i]) begin
                    acc[i] = 1'b1;
                    sb.push_back({IDB'(i), mul8(S_A[i*8 +: 8], S_B[i*8 +: 8])});
                end
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic drain();
        M_READY = 1'b1;
        S_VALID = '0;
        for (int k = 0; k < 60 && (sb.size() != 0 || BUSY); k++) tick();
        chk("drain_sb_empty", 32'(sb.size()), 32'd0);
        chk("drain_busy", 32'(BUSY), 32'd0);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        tick();
        RESET = 1'b0;
    endtask

    vec_t vecs[6];
    logic [7:0] hold_p;
    logic [IDB-1:0] hold_id;

    initial begin
        vecs[0] = '{0, 8'd7,    8'hFD, 8'hEB};  // 7 * -3 = -21
        vecs[1] = '{0, 8'h80,   8'h80, 8'h00};  // -128 * -128 wraps to 0
        vecs[2] = '{0, 8'd127,  8'd2,  8'hFE};  // 254 wraps to -2
        vecs[3] = '{2, 8'hFF,   8'hFF, 8'h01};  // -1 * -1
        vecs[4] = '{3, 8'd16,   8'd16, 8'h00};  // 256 wraps to 0
        vecs[5] = '{1, 8'hFB,   8'd25, 8'h83};  // -5 * 25 = -125

        RESET   = 1'b1;
        S_VALID = '0;
        S_A     = '0;
        S_B     = '0;
        M_READY = 1'b1;
        @(posedge CLK); #1;
        do_reset();

        // Reset state
        chk("rst_m_valid", 32'(M_VALID), 32'd0);
        chk("rst_busy",    32'(BUSY),    32'd0);
        chk("rst_s_ready", 32'(S_READY), 32'd0);
        chk("rst_m_id",    32'(M_ID),    32'd0);

        // Single requests: same-cycle grant and 3-cycle latency
        for (int v = 0; v < 6; v++) begin
            S_VALID = N'(1) << vecs[v].id;
            S_A[vecs[v].id*8 +: 8] = vecs[v].a;
            S_B[vecs[v].id*8 +: 8] = vecs[v].b;
            #1;
            chk("vec_s_ready", 32'(S_READY), 32'(N'(1) << vecs[v].id));
            tick();
            S_VALID = '0;
            chk("vec_busy", 32'(BUSY), 32'd1);
            tick();
            tick();
            chk("vec_m_valid", 32'(M_VALID), 32'd1);
            chk("vec_m_id",    32'(M_ID),    32'(vecs[v].id));
            chk("vec_m_p",     32'(M_P),     32'(vecs[v].p));
            tick();
        end
        drain();

        // All requesters valid: grants rotate 0,1,2,3,...
        do_reset();
        for (int i = 0; i < N; i++) begin
            S_A[i*8 +: 8] = 8'(i + 1);
            S_B[i*8 +: 8] = 8'(i + 10);
        end
        S_VALID = '1;
        for (int k = 0; k < 10; k++) begin
            #1;
            chk("rr_grant", 32'(S_READY), 32'(N'(1) << (k % N)));
            tick();
        end
        drain();

        // Stall with 3 entries in flight
        for (int k = 0; k < 3; k++) begin
            S_VALID = 4'b0001;
            S_A[7:0] = 8'(k * 3 + 5);
            S_B[7:0] = 8'(8'hF0 + k);
            tick();
        end
        S_VALID = '1;
        M_READY = 1'b0;
        #1;
        hold_p  = M_P;
        hold_id = M_ID;
        chk("stall_entry_valid", 32'(M_VALID), 32'd1);
        chk("stall_entry_p", 32'(hold_p), 32'(mul8(8'd5, 8'hF0)));
        for (int k = 0; k < 5; k++) begin
            chk("stall_s_ready", 32'(S_READY), 32'd0);
            chk("stall_m_valid", 32'(M_VALID), 32'd1);
            chk("stall_m_p",     32'(M_P),     32'(hold_p));
            chk("stall_m_id",    32'(M_ID),    32'(hold_id));
            tick();
            #1;
        end
        S_VALID = '0;
        drain();

        // Reset with 2 entries in flight
        for (int k = 0; k < 2; k++) begin
            S_VALID = N'(1) << (k + 1);
            S_A[(k+1)*8 +: 8] = 8'd9;
            S_B[(k+1)*8 +: 8] = 8'd9;
            tick();
        end
        S_VALID = '0;
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
        chk("midrst_m_valid", 32'(M_VALID), 32'd0);
        chk("midrst_busy",    32'(BUSY),    32'd0);
        for (int k = 0; k < 4; k++) begin
            chk("midrst_no_stale", 32'(M_VALID), 32'd0);
            tick();
        end
        S_VALID = '1;
        #1;
        chk("midrst_ptr0", 32'(S_READY), 32'd1);
        S_VALID = '0;
        drain();

        // Random traffic against the scoreboard
        acc = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!S_VALID[i] || acc[i]) begin
                    S_VALID[i] = ($urandom_range(0, 99) < 55);
                    S_A[i*8 +: 8] = 8'($urandom);
                    S_B[i*8 +: 8] = 8'($urandom);
                end
            end
            M_READY = ($urandom_range(0, 99) < 70);
            tick();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
